// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, valid/ready handshakes
module serial_subtractor #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_diff,
    output logic             o_busy
);

    // Counter wide enough to hold WIDTH-1; a WIDTH=1 build still needs one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH:0]   r_diff;
    logic             r_valid;

    logic             w_d;
    logic             w_br_n;
    logic [WIDTH-1:0] w_res_n;

    // One full-subtractor slice on the current LSBs; new bit enters the result from the top.
    always_comb begin
        w_d     = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
        w_br_n  = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
        w_res_n = WIDTH'({w_d, r_res} >> 1);
    end

    // Control FSM and serial datapath; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_res  <= w_res_n;
                    r_br   <= w_br_n;
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_diff  <= {w_br_n, w_res_n};
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result stays put until downstream takes it; o_diff keeps its value afterwards.
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state == S_BUSY);
    assign o_valid = r_valid;
    assign o_diff  = r_diff;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 10;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          o_valid;
    logic          i_ready;
    logic [W:0]    o_diff;
    logic          o_busy;

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .a       (a),
        .b       (b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_diff  (o_diff),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modulo-2^(W+1) subtraction.
    function automatic logic [W:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y)) & ((1 << (W + 1)) - 1);
        return r[W:0];
    endfunction

    // Presents one operand pair and waits for the result; lat = edges from accept to o_valid, -1 on timeout.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic rdy,
                          output logic [W:0] d, output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        a       = xa;
        b       = xb;
        i_valid = 1'b1;
        i_ready = rdy;
        @(negedge clk);
        i_valid = 1'b0;
        a       = W'($urandom_range(1023, 0));
        b       = W'($urandom_range(1023, 0));
        lat     = 0;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) lat = -1;
        d = o_diff;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy got=%b exp=0", o_busy); end
        checks++; if (o_diff !== '0) begin failures++; $display("FAIL reset_o_diff got=%h exp=000", o_diff); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W:0] d;
        int lat;
        run_op(10'd5, 10'd3, 1'b1, d, lat);
        checks++; if (d !== 11'h002) begin failures++; $display("FAIL basic_diff got=%h exp=002", d); end
        checks++; if (lat !== W) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_in_done got=%b exp=0", o_ready); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_return got=%b exp=1", o_ready); end
        checks++; if (o_diff !== 11'h002) begin failures++; $display("FAIL basic_diff_kept got=%h exp=002", o_diff); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{10'd3, 10'd0, 10'd1023, 10'd0, 10'd777};
        logic [W-1:0] vb [5] = '{10'd5, 10'd1023, 10'd0, 10'd0, 10'd777};
        logic [W:0]   ve [5] = '{11'h7FE, 11'h401, 11'h3FF, 11'h000, 11'h000};
        logic [W:0] d;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], 1'b1, d, lat);
            checks++;
            if (d !== ve[i]) begin
                failures++;
                $display("FAIL directed_diff a=%0d b=%0d got=%h exp=%h", va[i], vb[i], d, ve[i]);
            end
            checks++;
            if (d[W] !== (va[i] < vb[i])) begin
                failures++;
                $display("FAIL directed_borrow a=%0d b=%0d got=%b exp=%b", va[i], vb[i], d[W], va[i] < vb[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        logic [W:0] d;
        int lat;
        run_op(10'd100, 10'd37, 1'b0, d, lat);
        checks++; if (d !== 11'd63) begin failures++; $display("FAIL hold_diff got=%h exp=%h", d, 11'd63); end
        for (int i = 0; i < 7; i++) begin
            i_valid = 1'b1;
            a       = W'($urandom_range(1023, 0));
            b       = W'($urandom_range(1023, 0));
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_diff !== 11'd63 || o_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got valid=%b diff=%h ready=%b exp valid=1 diff=03f ready=0",
                         i, o_valid, o_diff, o_ready);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", o_valid); end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_no_accept got busy=%b ready=%b exp busy=0 ready=1", o_busy, o_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [W:0] d;
        int lat;
        a       = 10'd200;
        b       = 10'd1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", o_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_diff !== '0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got ready=%b valid=%b diff=%h busy=%b exp 1 0 000 0",
                     o_ready, o_valid, o_diff, o_busy);
        end
        run_op(10'd9, 10'd2, 1'b1, d, lat);
        checks++; if (d !== 11'h007) begin failures++; $display("FAIL abort_next_diff got=%h exp=007", d); end
        checks++; if (lat !== W) begin failures++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, W); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W:0]   exp_q[$];
        logic [W:0]   exp_v;
        logic         p_iv, p_ir, p_or, p_ov;
        logic [W-1:0] p_a, p_b;
        logic [W:0]   p_d;
        int accepted, results, bad, cyc;
        accepted = 0;
        results  = 0;
        bad      = 0;
        cyc      = 0;
        p_iv = 1'b0; p_ir = 1'b0; p_or = o_ready; p_ov = o_valid; p_a = '0; p_b = '0; p_d = o_diff;
        while ((accepted < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            if (p_or && p_iv) begin
                exp_q.push_back(ref_diff(p_a, p_b));
                accepted++;
            end
            if (p_ov && p_ir) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                results++;
                if (p_d !== exp_v) begin
                    bad++;
                    if (bad <= 10) $display("FAIL b2b_diff n=%0d got=%h exp=%h", results, p_d, exp_v);
                end
            end
            if (p_ov && !p_ir && (o_valid !== 1'b1 || o_diff !== p_d)) begin
                bad++;
                if (bad <= 10) $display("FAIL b2b_hold got valid=%b diff=%h exp valid=1 diff=%h", o_valid, o_diff, p_d);
            end
            p_or = o_ready;
            p_ov = o_valid;
            p_d  = o_diff;
            p_iv = (accepted < 1000) && ($urandom_range(3, 0) != 0);
            p_ir = ($urandom_range(1, 0) == 1);
            p_a  = W'($urandom_range(1023, 0));
            p_b  = W'($urandom_range(1023, 0));
            if ($urandom_range(7, 0) == 0) p_a = '0;
            if ($urandom_range(7, 0) == 0) p_b = '1;
            i_valid = p_iv;
            i_ready = p_ir;
            a       = p_a;
            b       = p_b;
            @(negedge clk);
            cyc++;
        end
        i_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_errors got=%0d exp=0", bad); end
        checks++; if (accepted !== 1000) begin failures++; $display("FAIL b2b_accepted got=%0d exp=1000", accepted); end
        checks++; if (results !== 1000) begin failures++; $display("FAIL b2b_results got=%0d exp=1000", results); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_directed();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
